// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencer and the stage
// registers it drives.
//   pipe_state_e    : sequencer states (RUN, MEM_WAIT, HALT)
//   NOP_INSTR       : instruction word loaded into a stage register on clear
//                     (addi x0, x0, 0)
//   load_use_hazard : detects a load in EX feeding a source operand in ID
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hazard(
        input logic                  mem_read_ex,
        input logic [REG_ADDR_W-1:0] rd_ex,
        input logic [REG_ADDR_W-1:0] rs1_id,
        input logic [REG_ADDR_W-1:0] rs2_id,
        input logic                  rs1_used_id,
        input logic                  rs2_used_id
    );
        return mem_read_ex && (rd_ex != '0) &&
               (((rd_ex == rs1_id) && rs1_used_id) ||
                ((rd_ex == rs2_id) && rs2_used_id));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock, rising edge
//   i_clr   : synchronous clear (wins over i_inc)
//   i_inc   : count one this cycle
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: clear is sampled only on the clock edge (synchronous), so it
    // lives inside the clocked block and not in the sensitivity list.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments for all clocked state so every
        // register samples pre-edge values regardless of statement order.
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the pipeline stage registers. Produces load enables
// and active-low clears for PC, IF/ID, ID/EX, EX/MEM and MEM/WB to stall on
// load-use hazards, squash on taken branches, freeze during slow data-memory
// accesses (bounded by MEM_TIMEOUT) and halt on debug request.
//   i_clk, i_reset            : clock / synchronous active-high reset
//   i_mem_read_ex, i_rd_ex    : EX instruction is a load, and its destination
//   i_rs1_id, i_rs2_id        : ID source registers
//   i_rs1_used_id, i_rs2_used_id : ID instruction actually reads rs1 / rs2
//   i_pc_sel_ex               : taken branch/jump resolved in EX
//   i_dmem_req, i_dmem_ack    : MEM-stage handshake request / completion
//   i_halt                    : debug halt request
//   o_enable_*                : stage register load enables (Mealy)
//   o_reset_*                 : stage register clears, active low (Mealy)
//   o_mem_err                 : sticky dmem timeout flag
//   o_halted                  : sequencer is in HALT
//   o_stall_cnt, o_flush_cnt  : saturating performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_mem_read_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_ex,
    input  logic [REG_ADDR_W-1:0] i_rs1_id,
    input  logic [REG_ADDR_W-1:0] i_rs2_id,
    input  logic                  i_rs1_used_id,
    input  logic                  i_rs2_used_id,
    input  logic                  i_pc_sel_ex,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_ack,
    input  logic                  i_halt,
    output logic                  o_enable_pc,
    output logic                  o_enable_id,
    output logic                  o_enable_ex,
    output logic                  o_enable_mem,
    output logic                  o_enable_wb,
    output logic                  o_reset_id,
    output logic                  o_reset_ex,
    output logic                  o_reset_mem,
    output logic                  o_reset_wb,
    output logic                  o_mem_err,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    pipe_state_e      r_state;
    logic [TMO_W-1:0] r_tmo;
    logic             r_mem_err;

    pipe_state_e      w_next_state;
    logic             w_freeze;     // every stage holds this cycle
    logic             w_rules;      // branch / load-use rules apply this cycle
    logic             w_timeout;    // MEM_WAIT exits without an ack
    logic             w_hazard;
    logic             w_branch;
    logic             w_load_use;
    logic [4:0]       w_enable;     // {pc, id, ex, mem, wb}
    logic [3:0]       w_reset_n;    // {id, ex, mem, wb}

    // -------------------------------------------------------------------------
    // Next-state decode. In RUN the priority is dmem wait, halt, then the
    // branch/load-use rules. The MEM_WAIT exit cycle lets the pipeline advance
    // and applies branch/load-use, but deliberately does not look at i_halt:
    // a halt raised during the wait is taken from RUN on the following cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case leaves it unassigned (no latch inferred).
        w_next_state = r_state;
        w_freeze     = 1'b0;
        w_rules      = 1'b0;
        w_timeout    = 1'b0;

        unique case (r_state)
            RUN: begin
                if (i_dmem_req && !i_dmem_ack) begin
                    w_freeze     = 1'b1;
                    w_next_state = MEM_WAIT;
                end else if (i_halt) begin
                    w_freeze     = 1'b1;
                    w_next_state = HALT;
                end else begin
                    w_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ack || (r_tmo == TMO_LAST)) begin
                    w_rules      = 1'b1;
                    w_timeout    = !i_dmem_ack;
                    w_next_state = RUN;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            HALT: begin
                w_freeze = 1'b1;
                if (!i_halt) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    assign w_hazard   = load_use_hazard(i_mem_read_ex, i_rd_ex, i_rs1_id, i_rs2_id,
                                        i_rs1_used_id, i_rs2_used_id);
    assign w_branch   = w_rules && i_pc_sel_ex;
    // A taken branch squashes the ID instruction anyway, so its hazard is moot.
    assign w_load_use = w_rules && !i_pc_sel_ex && w_hazard;

    // -------------------------------------------------------------------------
    // Mealy enable/clear outputs. Reset flushes every stage register to a NOP
    // while leaving enables high so the clear actually loads.
    // -------------------------------------------------------------------------
    always_comb begin
        w_enable  = 5'b11111;
        w_reset_n = 4'b1111;
        if (i_reset) begin
            w_reset_n = 4'b0000;
        end else if (w_freeze) begin
            w_enable = 5'b00000;
        end else if (w_branch) begin
            // Squash the two younger instructions in IF/ID and ID/EX.
            w_reset_n = 4'b0011;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            w_enable  = 5'b00111;
            w_reset_n = 4'b1011;
        end
    end

    assign {o_enable_pc, o_enable_id, o_enable_ex, o_enable_mem, o_enable_wb} = w_enable;
    assign {o_reset_id, o_reset_ex, o_reset_mem, o_reset_wb}                  = w_reset_n;

    // -------------------------------------------------------------------------
    // State, timeout counter and sticky error. The timeout counter is held at
    // zero outside MEM_WAIT, which clears it on every entry to the wait.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= RUN;
            r_tmo     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_mem_err <= r_mem_err | w_timeout;
            if (r_state == MEM_WAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign o_mem_err = r_mem_err;
    assign o_halted  = (r_state == HALT) && !i_reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_reset),
        .i_inc   (!o_enable_pc && !i_reset),
        .o_count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_reset),
        .i_inc   (w_branch && !i_reset),
        .o_count (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed vectors for pipe_ctrl with MEM_TIMEOUT=4 and 4-bit counters (so the
// stall counter saturates within the sequence). Each vector drives the inputs
// just after a rising edge and pushes its hand-computed expected outputs; a
// monitor on the falling edge pops and compares. Registered outputs seen in a
// cycle reflect only the edges before it.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic             clk;
    logic             reset;
    logic             mem_read_ex;
    logic [4:0]       rd_ex, rs1_id, rs2_id;
    logic             rs1_used_id, rs2_used_id;
    logic             pc_sel_ex, dmem_req, dmem_ack, halt;
    logic             en_pc, en_id, en_ex, en_mem, en_wb;
    logic             rst_id, rst_ex, rst_mem, rst_wb;
    logic             mem_err, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string            name;
        logic [4:0]       en;
        logic [3:0]       rs;
        logic             halted;
        logic             err;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_mem_read_ex (mem_read_ex),
        .i_rd_ex       (rd_ex),
        .i_rs1_id      (rs1_id),
        .i_rs2_id      (rs2_id),
        .i_rs1_used_id (rs1_used_id),
        .i_rs2_used_id (rs2_used_id),
        .i_pc_sel_ex   (pc_sel_ex),
        .i_dmem_req    (dmem_req),
        .i_dmem_ack    (dmem_ack),
        .i_halt        (halt),
        .o_enable_pc   (en_pc),
        .o_enable_id   (en_id),
        .o_enable_ex   (en_ex),
        .o_enable_mem  (en_mem),
        .o_enable_wb   (en_wb),
        .o_reset_id    (rst_id),
        .o_reset_ex    (rst_ex),
        .o_reset_mem   (rst_mem),
        .o_reset_wb    (rst_wb),
        .o_mem_err     (mem_err),
        .o_halted      (halted),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got en=%b rs=%b h=%b err=%b stall=%0d flush=%0d, want en=%b rs=%b h=%b err=%b stall=%0d flush=%0d",
                     name, got[21:17], got[16:13], got[12], got[11], got[10:7], got[6:3],
                     want[21:17], want[16:13], want[12], want[11], want[10:7], want[6:3]);
        end
    endtask

    // Monitor: compares whatever expectation is pending on each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name,
                  {en_pc, en_id, en_ex, en_mem, en_wb, rst_id, rst_ex, rst_mem, rst_wb,
                   halted, mem_err, stall_cnt, flush_cnt, 3'b000},
                  {e.en, e.rs, e.halted, e.err, e.stall, e.flush, 3'b000});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        mem_read_ex = 1'b0;
        rd_ex       = 5'd0;
        rs1_id      = 5'd0;
        rs2_id      = 5'd0;
        rs1_used_id = 1'b0;
        rs2_used_id = 1'b0;
        pc_sel_ex   = 1'b0;
        dmem_req    = 1'b0;
        dmem_ack    = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2);
        mem_read_ex = 1'b1;
        rd_ex       = rd;
        rs1_id      = r1;
        rs1_used_id = u1;
        rs2_id      = r2;
        rs2_used_id = u2;
    endtask

    // Push the expectation for the inputs currently applied, then advance.
    task automatic expect_out(input string name, input logic [4:0] en, input logic [3:0] rs,
                              input logic h, input logic err, input int st, input int fl);
        exp_t e;
        e.name   = name;
        e.en     = en;
        e.rs     = rs;
        e.halted = h;
        e.err    = err;
        e.stall  = st[CNT_W-1:0];
        e.flush  = fl[CNT_W-1:0];
        exp_q.push_back(e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b1;                  expect_out("reset",       5'b11111, 4'b0000, 0, 0,  0, 0);
        idle();                        expect_out("idle",        5'b11111, 4'b1111, 0, 0,  0, 0);
        // Load-use
        idle(); lu(5, 5, 1, 0, 0);     expect_out("lu_rs1",      5'b00111, 4'b1011, 0, 0,  0, 0);
        idle();                        expect_out("lu_after",    5'b11111, 4'b1111, 0, 0,  1, 0);
        idle(); lu(0, 0, 1, 0, 0);     expect_out("lu_rd0",      5'b11111, 4'b1111, 0, 0,  1, 0);
        idle(); lu(7, 3, 1, 7, 1);     expect_out("lu_rs2",      5'b00111, 4'b1011, 0, 0,  1, 0);
        idle(); lu(7, 3, 1, 7, 0);     expect_out("lu_unused",   5'b11111, 4'b1111, 0, 0,  2, 0);
        idle(); lu(5, 5, 1, 0, 0); mem_read_ex = 1'b0;
                                       expect_out("lu_noload",   5'b11111, 4'b1111, 0, 0,  2, 0);
        // Branch with a simultaneous hazard
        idle(); lu(5, 5, 1, 0, 0); pc_sel_ex = 1'b1;
                                       expect_out("br_lu",       5'b11111, 4'b0011, 0, 0,  2, 0);
        idle();                        expect_out("br_after",    5'b11111, 4'b1111, 0, 0,  2, 1);
        // Dmem wait, ack on the fourth cycle
        idle(); dmem_req = 1'b1;       expect_out("dm_req",      5'b00000, 4'b1111, 0, 0,  2, 1);
        idle(); dmem_req = 1'b1;       expect_out("dm_w1",       5'b00000, 4'b1111, 0, 0,  3, 1);
        idle(); dmem_req = 1'b1;       expect_out("dm_w2",       5'b00000, 4'b1111, 0, 0,  4, 1);
        idle(); dmem_req = 1'b1; dmem_ack = 1'b1;
                                       expect_out("dm_ack",      5'b11111, 4'b1111, 0, 0,  5, 1);
        idle();                        expect_out("dm_after",    5'b11111, 4'b1111, 0, 0,  5, 1);
        idle(); dmem_req = 1'b1; dmem_ack = 1'b1;
                                       expect_out("dm_same_ack", 5'b11111, 4'b1111, 0, 0,  5, 1);
        // Branch in the MEM_WAIT exit cycle
        idle(); dmem_req = 1'b1;       expect_out("dm_req2",     5'b00000, 4'b1111, 0, 0,  5, 1);
        idle(); dmem_req = 1'b1; dmem_ack = 1'b1; pc_sel_ex = 1'b1;
                                       expect_out("dm_ack_br",   5'b11111, 4'b0011, 0, 0,  6, 1);
        idle();                        expect_out("dm_br_after", 5'b11111, 4'b1111, 0, 0,  6, 2);
        // Timeout: four frozen cycles, then exit, error the cycle after
        idle(); dmem_req = 1'b1;       expect_out("to_req",      5'b00000, 4'b1111, 0, 0,  6, 2);
        idle(); dmem_req = 1'b1;       expect_out("to_w0",       5'b00000, 4'b1111, 0, 0,  7, 2);
        idle(); dmem_req = 1'b1;       expect_out("to_w1",       5'b00000, 4'b1111, 0, 0,  8, 2);
        idle(); dmem_req = 1'b1;       expect_out("to_w2",       5'b00000, 4'b1111, 0, 0,  9, 2);
        idle(); dmem_req = 1'b1;       expect_out("to_exit",     5'b11111, 4'b1111, 0, 0, 10, 2);
        idle();                        expect_out("to_err",      5'b11111, 4'b1111, 0, 1, 10, 2);
        idle();                        expect_out("to_sticky",   5'b11111, 4'b1111, 0, 1, 10, 2);
        // Halt raised during MEM_WAIT is taken only after the ack
        idle(); dmem_req = 1'b1;       expect_out("hw_req",      5'b00000, 4'b1111, 0, 1, 10, 2);
        idle(); dmem_req = 1'b1; halt = 1'b1;
                                       expect_out("hw_halt",     5'b00000, 4'b1111, 0, 1, 11, 2);
        idle(); dmem_req = 1'b1; dmem_ack = 1'b1; halt = 1'b1;
                                       expect_out("hw_ack",      5'b11111, 4'b1111, 0, 1, 12, 2);
        idle(); halt = 1'b1;           expect_out("hw_enter",    5'b00000, 4'b1111, 0, 1, 12, 2);
        idle(); halt = 1'b1;           expect_out("hw_halted",   5'b00000, 4'b1111, 1, 1, 13, 2);
        idle();                        expect_out("hw_release",  5'b00000, 4'b1111, 1, 1, 14, 2);
        idle();                        expect_out("hw_run",      5'b11111, 4'b1111, 0, 1, 15, 2);
        // Stall counter is at all-ones: it must not wrap
        idle(); lu(9, 0, 0, 9, 1);     expect_out("sat_lu",      5'b00111, 4'b1011, 0, 1, 15, 2);
        idle();                        expect_out("sat_hold",    5'b11111, 4'b1111, 0, 1, 15, 2);
        // Reset mid-wait
        idle(); dmem_req = 1'b1;       expect_out("rw_req",      5'b00000, 4'b1111, 0, 1, 15, 2);
        idle(); dmem_req = 1'b1; reset = 1'b1;
                                       expect_out("rw_reset",    5'b11111, 4'b0000, 0, 1, 15, 2);
        idle();                        expect_out("rw_after",    5'b11111, 4'b1111, 0, 0,  0, 0);
        idle(); dmem_ack = 1'b1;       expect_out("rw_stray_ack",5'b11111, 4'b1111, 0, 0,  0, 0);
        // Reset while halted
        idle(); halt = 1'b1;           expect_out("rh_enter",    5'b00000, 4'b1111, 0, 0,  0, 0);
        idle(); halt = 1'b1; reset = 1'b1;
                                       expect_out("rh_reset",    5'b11111, 4'b0000, 0, 0,  1, 0);
        idle();                        expect_out("rh_after",    5'b11111, 4'b1111, 0, 0,  0, 0);
        idle();
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
